// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FSM state type, opcodes and IEEE-754 constants for the multicycle FPU
package fpu_pkg;
    typedef enum logic [2:0] {IDLE, UNPACK, EXEC, NORM, PACK} state_t;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;
    localparam logic [31:0] CANON_NAN = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    localparam logic signed [9:0] BIAS = 10'sd127;
endpackage

// File: rtl/fpu_normalize.sv
// fpu_normalize: normalizes a 48-bit mantissa (hidden bit at 46, carry at 47) and adjusts the exponent
module fpu_normalize (
    input  logic [47:0]       m,
    input  logic signed [9:0] e,
    output logic [22:0]       frac,
    output logic signed [9:0] e_out,
    output logic              lost
);
    logic [5:0] lz;
    logic [45:0] shl;
    always_comb begin
        lz = 6'd47;
        for (int i = 0; i < 47; i++)
            if (m[i]) lz = 6'(46 - i);
        shl = 46'(m[46:0] << lz);
        frac = m[47] ? m[46:24] : shl[45:23];
        e_out = m[47] ? e + 10'sd1 : e - $signed({4'b0, lz});
        lost = m[47] ? |m[23:0] : |shl[22:0];
    end
endmodule

// File: rtl/fpu_multicycle.sv
// fpu_multicycle: single-precision FADD/FSUB/FMUL, truncating, fixed four-cycle latency
module fpu_multicycle
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  FPUControl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic [31:0] FPUResult,
    output logic [3:0]  FPUFlags,
    output logic        busy,
    output logic        done
);
    state_t state;
    logic [31:0] a_r, b_r;
    logic [1:0] op_r;
    logic sa, sb, za, zb, nan_a, nan_b, inf_a, inf_b, mul, swap, inf_sign;
    logic [23:0] ma, mb;
    logic u_sp;
    logic [31:0] u_res;
    logic [3:0] u_flags;
    logic x_sp, x_mul, x_sub, x_sgn;
    logic [31:0] x_res;
    logic [3:0] x_flags;
    logic [23:0] x_mx, x_my;
    logic [7:0] x_ex, x_ey, d;
    logic [4:0] sh;
    logic [49:0] ext;
    logic [24:0] sum;
    logic n_sp, n_sgn, n_zero, n_sticky;
    logic [31:0] n_res;
    logic [3:0] n_flags;
    logic [47:0] n_m;
    logic signed [9:0] n_e, e_out;
    logic [22:0] frac;
    logic lost, inexact;
    logic [31:0] res;
    logic [3:0] flags;

    assign sa = a_r[31];
    assign sb = b_r[31] ^ (op_r == OP_SUB);
    assign mul = op_r == OP_MUL;
    assign za = a_r[30:23] == 8'h00;
    assign zb = b_r[30:23] == 8'h00;
    assign nan_a = &a_r[30:23] && |a_r[22:0];
    assign nan_b = &b_r[30:23] && |b_r[22:0];
    assign inf_a = &a_r[30:23] && ~|a_r[22:0];
    assign inf_b = &b_r[30:23] && ~|b_r[22:0];
    assign ma = za ? 24'h0 : {1'b1, a_r[22:0]};
    assign mb = zb ? 24'h0 : {1'b1, b_r[22:0]};
    // larger magnitude always goes first so the add path never needs a negative sum
    assign swap = (zb ? 31'h0 : b_r[30:0]) > (za ? 31'h0 : a_r[30:0]);
    assign inf_sign = mul ? sa ^ sb : (inf_a ? sa : sb);

    always_comb begin
        u_sp = 1'b1;
        u_res = 32'h0;
        u_flags = 4'b0100;
        if (op_r != OP_RSV) begin
            if (nan_a || nan_b || (inf_a && (mul ? zb : inf_b && sa != sb)) || (inf_b && mul && za)) begin
                u_res = CANON_NAN;
                u_flags = 4'b0000;
            end else if (inf_a || inf_b) begin
                u_res = {inf_sign, POS_INF[30:0]};
                u_flags = {inf_sign, 3'b000};
            end else if (mul && (za || zb)) begin
                u_res = {sa ^ sb, 31'h0};
                u_flags = {sa ^ sb, 3'b100};
            end else begin
                u_sp = 1'b0;
            end
        end
    end

    assign d = x_ex - x_ey;
    assign sh = d > 8'd26 ? 5'd26 : d[4:0];
    assign ext = {x_my, 26'h0} >> sh;
    assign sum = x_sub ? {1'b0, x_mx} - {1'b0, ext[49:26]} : {1'b0, x_mx} + {1'b0, ext[49:26]};

    fpu_normalize u_norm (.m(n_m), .e(n_e), .frac(frac), .e_out(e_out), .lost(lost));

    assign inexact = lost | n_sticky;

    always_comb begin
        res = {n_sgn, e_out[7:0], frac};
        flags = {n_sgn, 1'b0, inexact, 1'b0};
        if (n_sp) begin
            res = n_res;
            flags = n_flags;
        end else if (n_zero) begin
            res = 32'h0;
            flags = 4'b0100;
        end else if (e_out > 10'sd254) begin
            res = {n_sgn, POS_INF[30:0]};
            flags = {n_sgn, 1'b0, inexact, 1'b1};
        end else if (e_out < 10'sd1) begin
            res = {n_sgn, 31'h0};
            flags = {n_sgn, 3'b110};
        end
    end

    // stage registers load every cycle; only the state that owns them reads them
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_r <= SrcA;
            b_r <= SrcB;
            op_r <= FPUControl;
        end
        x_sp <= u_sp;
        x_res <= u_res;
        x_flags <= u_flags;
        x_mul <= mul;
        x_sub <= sa ^ sb;
        x_sgn <= mul ? sa ^ sb : (swap ? sb : sa);
        x_mx <= swap ? mb : ma;
        x_my <= swap ? ma : mb;
        x_ex <= swap ? b_r[30:23] : a_r[30:23];
        x_ey <= swap ? a_r[30:23] : b_r[30:23];
        n_sp <= x_sp;
        n_res <= x_res;
        n_flags <= x_flags;
        n_sgn <= x_sgn;
        n_zero <= !x_mul && sum == 25'h0;
        n_sticky <= !x_mul && |ext[25:0];
        n_m <= x_mul ? x_mx * x_my : {sum, 23'h0};
        n_e <= x_mul ? $signed({2'b0, x_ex}) + $signed({2'b0, x_ey}) - BIAS : $signed({2'b0, x_ex});
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            FPUResult <= 32'h0;
            FPUFlags <= 4'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= UNPACK;
                    busy <= 1'b1;
                end
                UNPACK: state <= EXEC;
                EXEC: state <= NORM;
                NORM: begin
                    state <= PACK;
                    done <= 1'b1;
                    FPUResult <= res;
                    FPUFlags <= flags;
                end
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/fpu_multicycle.md
FPU_MULTICYCLE -- requirements
Module: fpu_multicycle

Interface
REQ-001 The block SHALL have exactly the following ports, one per line as name, direction, width, meaning:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  launches an operation; sampled only in IDLE.
- FPUControl  input  2  operation select: 00 FADD, 01 FMUL, 10 FSUB, 11 reserved.
- SrcA  input  32  operand A, IEEE-754 single precision.
- SrcB  input  32  operand B, IEEE-754 single precision.
- FPUResult  output  32  result, IEEE-754 single precision.
- FPUFlags  output  4  {N,Z,C,V}: N=result sign, Z=result zero, C=inexact (bits discarded), V=overflow.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; FPUResult/FPUFlags valid in that cycle.
REQ-002 Parameters: none.

Function
REQ-003 FSM states SHALL be IDLE, UNPACK, EXEC, NORM, PACK; transitions SHALL be IDLE->UNPACK on start, then UNPACK->EXEC->NORM->PACK->IDLE unconditionally.
REQ-004 On start in IDLE, SrcA, SrcB and FPUControl SHALL be captured; later input changes SHALL NOT affect the operation.
REQ-005 Latency SHALL be fixed: start high in cycle t -> done high in cycle t+4 for every opcode; busy high in cycles t+1..t+4.
REQ-006 start while busy SHALL be ignored, with no queuing.
REQ-007 start in the PACK cycle SHALL be ignored; the earliest accepted restart is cycle t+5.
REQ-008 FPUResult and FPUFlags SHALL update only in the done cycle and hold until the next done.
REQ-009 Opcode 11 SHALL produce FPUResult=0x00000000 and FPUFlags=0100 with normal latency.
REQ-010 FSUB SHALL equal FADD with the sign of SrcB inverted.
REQ-011 Denormal inputs (exp=0) SHALL be flushed to signed zero; a denormal result SHALL flush to signed zero with C=1.
REQ-012 Rounding SHALL be truncation (round-toward-zero); C=1 if any nonzero bit is discarded.
REQ-013 FADD SHALL align the smaller operand with a right shift capped at 26 bits, retaining guard/sticky for C.
REQ-014 FADD SHALL use a 25-bit signed magnitude sum.
REQ-015 An exact-zero sum SHALL give +0 (0x00000000).
REQ-016 FMUL SHALL compute a 24x24 -> 48-bit product in EXEC.
REQ-017 The FMUL result sign SHALL be the XOR of the operand signs.
REQ-018 The FMUL exponent SHALL be computed as expA+expB-127 in 10-bit signed arithmetic.
REQ-019 NORM SHALL left-shift by the leading-zero count or right-shift by 1 on carry-out, adjusting the exponent accordingly.
REQ-020 A biased exponent >=255 after NORM SHALL give a signed infinity with V=1.
REQ-021 Any NaN input SHALL give canonical NaN 0x7FC00000 with flags 0000.
REQ-022 inf-inf (effective subtraction) and inf*0 SHALL give canonical NaN with flags 0000.
REQ-023 An infinite operand otherwise SHALL give signed infinity with V=0.
REQ-024 Flags for a non-NaN result SHALL be N=sign, Z=(magnitude==0).

Reset
REQ-025 While reset is low at a clock edge, the state SHALL become IDLE and all outputs SHALL be forced to FPUResult=0, FPUFlags=0000, busy=0, done=0.
REQ-026 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-027 The first start SHALL be accepted in the first cycle after reset is released.

Structure
REQ-028 A shared package fpu_pkg SHALL hold the FSM state type, the FPUControl opcode constants, the canonical NaN and infinity constants, and the bias 127.
REQ-029 Exactly one sub-module, fpu_normalize, SHALL be used, combinational, performing leading-zero count, mantissa shift and exponent adjust.
REQ-030 The remaining datapath SHALL be pipeline registers between states, with no multicycle paths.

Verification
REQ-031 FADD 0x3F800000 + 0x40000000, start at t -> done at t+4, result 0x40400000, flags 0000, busy t+1..t+4.
REQ-032 FMUL 0x40400000 * 0xC0000000 -> 0xC0C00000, flags 1000.
REQ-033 FSUB 0x3F800000 - 0x3F800000 -> 0x00000000, flags 0100; FADD 0x3F800000 + 0x33800000 -> 0x3F800000, C=1.
REQ-034 FMUL 0x7F7FFFFF * 0x40000000 -> 0x7F800000, flags 0001; FADD 0x7F800000 + 0xFF800000 -> 0x7FC00000, flags 0000.
REQ-035 start held high for 10 cycles -> done at t+4 and t+9 only; SrcA changed at t+2 does not alter the first result.
REQ-036 reset low at t+2 of an FMUL -> no done, all outputs zero next cycle; a new FADD issued the cycle after release completes 4 cycles later with the correct result.
